control_setare_ceas: RTL and testbench
======================================

# control_setare_ceas

Time-keeping and setting controller that consumes the single-cycle short/long press pulses (`scurt_1..3`, `lung_1..3`) produced by the button press classifier. It keeps the running time (hh:mm:ss) and an alarm time, and lets the user edit them through a small menu state machine. Its outputs drive the display multiplexer and the buzzer.

## Interface
- `AL_ORE_INIT`, 7: alarm hour after reset (0–23).
- `AL_MIN_INIT`, 0: alarm minute after reset (0–59).
- `TIMEOUT_SET`, 30: ticks with no button pulse before the block leaves a set state.
- `DURATA_SUNA`, 60: ticks the alarm rings before it clears itself.
- `clock` in 1: system clock. All state updates on the negative edge, matching the pulse producer.
- `reset` in 1: synchronous, active-low.
- `tick_1s` in 1: one-cycle pulse, once per second.
- `scurt_1`, `scurt_2`, `scurt_3` in 1 each: short-press pulses, one cycle wide.
- `lung_1`, `lung_2`, `lung_3` in 1 each: long-press pulses, one cycle wide.
- `ore` out 5: current hour, 0–23.
- `minute` out 6: current minute, 0–59.
- `secunde` out 6: current second, 0–59.
- `al_ore` out 5: alarm hour.
- `al_minute` out 6: alarm minute.
- `mod` out 3: menu state encoding, listed under Operation.
- `blink` out 1: display blink enable for the field being edited.
- `alarma_activa` out 1: alarm armed.
- `suna` out 1: alarm ringing.

## Operation
- Menu states, with their `mod` encoding:
  - NORMAL = 0
  - SET_ORE = 1
  - SET_MIN = 2
  - SET_AL_ORE = 3
  - SET_AL_MIN = 4
- Button 1 transitions:
  - `lung_1` in NORMAL goes to SET_ORE and clears `secunde` to 0.
  - `lung_1` in any set state returns to NORMAL.
  - `scurt_1` steps SET_ORE → SET_MIN → SET_AL_ORE → SET_AL_MIN → NORMAL.
  - `scurt_1` in NORMAL is ignored.
- Button 2 in a set state: `scurt_2` adds 1 to the edited field and `lung_2` adds 10.
- Button 3 in a set state: `scurt_3` subtracts 1 from the edited field and `lung_3` subtracts 10.
- Field arithmetic is modulo 24 for hours and modulo 60 for minutes.
  - Examples: 23+1=0, 0−1=23, 55+10=5, 3−10=53.
- Button 3 in NORMAL:
  - `lung_3` toggles `alarma_activa`.
  - `scurt_3` is ignored, except that it stops the ringing (see below).
- Button 2 in NORMAL is ignored.
- Simultaneous pulses in one cycle: button 1 has priority over button 2, which has priority over button 3. Lower-priority pulses are dropped.
- Time-keeping:
  - `tick_1s` increments `secunde`.
  - 59 rolls over to 0 and carries into `minute`, and 59 minutes carry into `ore`.
  - 23:59:59 is followed by 00:00:00.
  - In SET_ORE and SET_MIN, ticks are ignored (the clock is frozen).
  - In NORMAL, SET_AL_ORE and SET_AL_MIN the clock keeps running.
  - If a tick and an edit arrive in the same cycle in an alarm state, both are applied.
- Set-state timeout:
  - An inactivity counter clears on any accepted pulse and on state entry.
  - Once TIMEOUT_SET ticks are counted, the block returns to NORMAL.
- `blink`:
  - 0 in NORMAL.
  - In set states it toggles on each tick and is forced to 1 on state entry.
- Alarm:
  - `suna` sets when a tick produces the time `al_ore:al_minute:00` while `alarma_activa`=1.
  - It clears on any `scurt_3` or `lung_3`, when `alarma_activa` goes to 0, or after DURATA_SUNA ticks.
  - A `lung_3` received while ringing only stops the ringing; it does not toggle `alarma_activa`.

## Timing
- Reset values (`reset`=0 at a clock edge):
  - `mod`=NORMAL, `ore`=0, `minute`=0, `secunde`=0.
  - `al_ore`=AL_ORE_INIT, `al_minute`=AL_MIN_INIT.
  - `alarma_activa`=0, `suna`=0, `blink`=0.
  - All internal counters = 0.
- All outputs are registered. Each pulse or tick takes effect exactly one edge later, with no combinational path from input to output.
- Reset asserted mid-edit discards the edit. Reset asserted during ringing clears `suna` at that edge.

## Configuration
- Macro: `CONTROL_SETARE_ALARMA_EN`.
- Defined: alarm registers, SET_AL_ORE/SET_AL_MIN states, `suna` logic and the alarm-enable toggle are all present.
- Undefined:
  - `scurt_1` in SET_MIN goes directly to NORMAL.
  - `al_ore`, `al_minute`, `alarma_activa` and `suna` are tied to 0.
  - `lung_3` in NORMAL is ignored.
  - `mod` never takes the values 3 or 4.

## Test plan
- Set the hour: reset, then `lung_1`, 3×`scurt_2`, `lung_1` → `mod` follows 1 then 0, `ore`=3, and `secunde` stays 0 while in SET_ORE despite ticks.
- Minute wrap: in SET_MIN with `minute`=55, apply `lung_2` → 5; then `scurt_3` ×6 → 59.
- Rollover: preload 23:59:58 and apply 2 ticks → 00:00:00.
- Alarm: alarm 07:00, `lung_3` (armed), time 06:59:59 plus a tick → `suna`=1 one edge later; `scurt_3` → `suna`=0 and `alarma_activa` still 1. Repeat with no button → `suna` clears after 60 ticks.
- Timeout and priority: enter SET_ORE and apply no pulses for 30 ticks → `mod`=0. Then `lung_1` and `scurt_2` in the same cycle → `mod`=1 and `ore` unchanged.

Source files
------------

// File: rtl/control_setare_ceas.sv
// Time-keeping and setting controller: running clock, alarm time and a small edit menu.
// Define CONTROL_SETARE_ALARMA_EN to build the alarm registers, alarm set states and buzzer logic.
module control_setare_ceas #(
  parameter int unsigned AL_ORE_INIT = 7,
  parameter int unsigned AL_MIN_INIT = 0,
  parameter int unsigned TIMEOUT_SET = 30,
  parameter int unsigned DURATA_SUNA = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       scurt_1,
  input  logic       scurt_2,
  input  logic       scurt_3,
  input  logic       lung_1,
  input  logic       lung_2,
  input  logic       lung_3,
  output logic [4:0] ore,
  output logic [5:0] minute,
  output logic [5:0] secunde,
  output logic [4:0] al_ore,
  output logic [5:0] al_minute,
  output logic [2:0] mod,
  output logic       blink,
  output logic       alarma_activa,
  output logic       suna
);

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    SET_ORE    = 3'd1,
    SET_MIN    = 3'd2,
    SET_AL_ORE = 3'd3,
    SET_AL_MIN = 3'd4
  } mod_e;

  typedef enum logic [2:0] {
    EV_NONE, EV_SCURT_1, EV_LUNG_1, EV_SCURT_2, EV_LUNG_2, EV_SCURT_3, EV_LUNG_3
  } ev_e;

  localparam int unsigned TW = $clog2(TIMEOUT_SET + 1);

  mod_e          r_state, w_state_nxt;
  ev_e           w_ev;
  logic [4:0]    r_ore, w_ore_inc, w_ore_edit;
  logic [5:0]    r_min, r_sec, w_min_inc, w_sec_inc, w_min_edit;
  logic [TW-1:0] r_inactiv;
  logic          r_blink;
  logic          w_in_set, w_clk_run, w_time_adv, w_entry, w_edit, w_up;
  logic [3:0]    w_delta;

  // Modular +/-delta for a field whose range is 0..m-1 (delta < m).
  function automatic logic [5:0] step_mod(input logic [5:0] v, input logic up,
                                          input logic [3:0] d, input logic [5:0] m);
    logic [6:0] s;
    if (up) begin
      s = {1'b0, v} + {3'b0, d};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end else if (v >= {2'b0, d}) begin
      s = {1'b0, v - {2'b0, d}};
    end else begin
      s = {1'b0, v} + {1'b0, m} - {3'b0, d};
    end
    return s[5:0];
  endfunction

  // Button 1 beats button 2 beats button 3; within a button the long press wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_ev = EV_NONE;
    if (lung_1)       w_ev = EV_LUNG_1;
    else if (scurt_1) w_ev = EV_SCURT_1;
    else if (lung_2)  w_ev = EV_LUNG_2;
    else if (scurt_2) w_ev = EV_SCURT_2;
    else if (lung_3)  w_ev = EV_LUNG_3;
    else if (scurt_3) w_ev = EV_SCURT_3;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == NORMAL) begin
      if (w_ev == EV_LUNG_1) w_state_nxt = SET_ORE;
    end else if (w_ev == EV_LUNG_1) begin
      w_state_nxt = NORMAL;
    end else if (w_ev == EV_SCURT_1) begin
      case (r_state)
        SET_ORE:    w_state_nxt = SET_MIN;
`ifdef CONTROL_SETARE_ALARMA_EN
        SET_MIN:    w_state_nxt = SET_AL_ORE;
        SET_AL_ORE: w_state_nxt = SET_AL_MIN;
`endif
        default:    w_state_nxt = NORMAL;
      endcase
    end else if (w_ev == EV_NONE && tick_1s && r_inactiv == TW'(TIMEOUT_SET - 1)) begin
      w_state_nxt = NORMAL;
    end
  end

  always_comb begin
    w_in_set   = (r_state != NORMAL);
    w_clk_run  = (r_state != SET_ORE) && (r_state != SET_MIN);
    w_time_adv = tick_1s && w_clk_run && !((r_state == NORMAL) && (w_ev == EV_LUNG_1));
    w_entry    = (w_state_nxt != r_state) && (w_state_nxt != NORMAL);
    w_edit     = w_in_set && (w_ev inside {EV_SCURT_2, EV_LUNG_2, EV_SCURT_3, EV_LUNG_3});
    w_up       = (w_ev == EV_SCURT_2) || (w_ev == EV_LUNG_2);
    w_delta    = ((w_ev == EV_LUNG_2) || (w_ev == EV_LUNG_3)) ? 4'd10 : 4'd1;
    w_ore_edit = 5'(step_mod({1'b0, r_ore}, w_up, w_delta, 6'd24));
    w_min_edit = step_mod(r_min, w_up, w_delta, 6'd60);
  end

  always_comb begin
    w_sec_inc = r_sec + 6'd1;
    w_min_inc = r_min;
    w_ore_inc = r_ore;
    if (r_sec == 6'd59) begin
      w_sec_inc = 6'd0;
      if (r_min == 6'd59) begin
        w_min_inc = 6'd0;
        w_ore_inc = (r_ore == 5'd23) ? 5'd0 : r_ore + 5'd1;
      end else begin
        w_min_inc = r_min + 6'd1;
      end
    end
  end

  always_ff @(negedge clock) begin
    if (!reset) begin
      r_state   <= NORMAL;
      r_inactiv <= '0;
      r_blink   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      if (w_state_nxt == NORMAL || w_state_nxt != r_state || w_ev != EV_NONE) r_inactiv <= '0;
      else if (tick_1s) r_inactiv <= r_inactiv + TW'(1);
      if (w_state_nxt == NORMAL) r_blink <= 1'b0;
      else if (w_entry)          r_blink <= 1'b1;
      else if (tick_1s)          r_blink <= ~r_blink;
    end
  end

  // Clock is frozen while hours/minutes are edited, so edit and advance never collide.
  always_ff @(negedge clock) begin
    if (!reset) begin
      r_ore <= '0;
      r_min <= '0;
      r_sec <= '0;
    end else if (r_state == NORMAL && w_ev == EV_LUNG_1) begin
      r_sec <= '0;
    end else if (w_time_adv) begin
      r_ore <= w_ore_inc;
      r_min <= w_min_inc;
      r_sec <= w_sec_inc;
    end else if (w_edit && r_state == SET_ORE) begin
      r_ore <= w_ore_edit;
    end else if (w_edit && r_state == SET_MIN) begin
      r_min <= w_min_edit;
    end
  end

  assign ore     = r_ore;
  assign minute  = r_min;
  assign secunde = r_sec;
  assign mod     = r_state;
  assign blink   = r_blink;

`ifdef CONTROL_SETARE_ALARMA_EN
  localparam int unsigned RW = $clog2(DURATA_SUNA + 1);

  logic [4:0]    r_al_ore, w_al_ore_edit;
  logic [5:0]    r_al_min, w_al_min_edit;
  logic          r_armed, r_suna, w_hit, w_stop;
  logic [RW-1:0] r_ring;

  always_comb begin
    w_al_ore_edit = 5'(step_mod({1'b0, r_al_ore}, w_up, w_delta, 6'd24));
    w_al_min_edit = step_mod(r_al_min, w_up, w_delta, 6'd60);
    w_stop        = (w_ev == EV_SCURT_3) || (w_ev == EV_LUNG_3);
    w_hit         = w_time_adv && r_armed && (w_ore_inc == r_al_ore) &&
                    (w_min_inc == r_al_min) && (w_sec_inc == 6'd0);
  end

  // A button-3 stop takes precedence over a same-cycle alarm hit.
  always_ff @(negedge clock) begin
    if (!reset) begin
      r_al_ore <= 5'(AL_ORE_INIT);
      r_al_min <= 6'(AL_MIN_INIT);
      r_armed  <= 1'b0;
      r_suna   <= 1'b0;
      r_ring   <= '0;
    end else begin
      if (w_edit && r_state == SET_AL_ORE) r_al_ore <= w_al_ore_edit;
      if (w_edit && r_state == SET_AL_MIN) r_al_min <= w_al_min_edit;
      if (r_state == NORMAL && w_ev == EV_LUNG_3 && !r_suna) r_armed <= ~r_armed;
      if (w_stop) begin
        r_suna <= 1'b0;
        r_ring <= '0;
      end else if (w_hit) begin
        r_suna <= 1'b1;
        r_ring <= '0;
      end else if (r_suna && tick_1s) begin
        if (r_ring == RW'(DURATA_SUNA - 1)) begin
          r_suna <= 1'b0;
          r_ring <= '0;
        end else begin
          r_ring <= r_ring + RW'(1);
        end
      end
    end
  end

  assign al_ore        = r_al_ore;
  assign al_minute     = r_al_min;
  assign alarma_activa = r_armed;
  assign suna          = r_suna;
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = ^{5'(AL_ORE_INIT), 6'(AL_MIN_INIT), 8'(DURATA_SUNA)};
  assign al_ore        = '0;
  assign al_minute     = '0;
  assign alarma_activa = 1'b0;
  assign suna          = 1'b0;
`endif

endmodule

// File: tb/tb_control_setare_ceas.sv
// Bench for control_setare_ceas: directed menu/clock/alarm scenarios followed by random pulses,
// every cycle compared with a seconds-of-day reference model.
module tb_control_setare_ceas;

  localparam logic [5:0] P_S1 = 6'b000001, P_L1 = 6'b000010, P_S2 = 6'b000100,
                         P_L2 = 6'b001000, P_S3 = 6'b010000, P_L3 = 6'b100000;
`ifdef CONTROL_SETARE_ALARMA_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif
  localparam int TIMEOUT = 30;
  localparam int DURATA  = 60;

  logic       clock = 1'b0, reset = 1'b0, tick_1s = 1'b0;
  logic       scurt_1 = 1'b0, scurt_2 = 1'b0, scurt_3 = 1'b0;
  logic       lung_1 = 1'b0, lung_2 = 1'b0, lung_3 = 1'b0;
  logic [4:0] ore, al_ore;
  logic [5:0] minute, secunde, al_minute;
  logic [2:0] mod;
  logic       blink, alarma_activa, suna;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: time as seconds of the day, menu state as its mod number.
  int m_secs, m_state, m_al_h, m_al_m, m_armed, m_suna, m_ring, m_inact, m_blink;

  control_setare_ceas #(
    .AL_ORE_INIT(7), .AL_MIN_INIT(0), .TIMEOUT_SET(TIMEOUT), .DURATA_SUNA(DURATA)
  ) dut (
    .clock(clock), .reset(reset), .tick_1s(tick_1s),
    .scurt_1(scurt_1), .scurt_2(scurt_2), .scurt_3(scurt_3),
    .lung_1(lung_1), .lung_2(lung_2), .lung_3(lung_3),
    .ore(ore), .minute(minute), .secunde(secunde),
    .al_ore(al_ore), .al_minute(al_minute), .mod(mod),
    .blink(blink), .alarma_activa(alarma_activa), .suna(suna)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_state = 0; m_al_h = ALARM ? 7 : 0; m_al_m = 0;
    m_armed = 0; m_suna = 0; m_ring = 0; m_inact = 0; m_blink = 0;
  endtask

  task automatic model_step(input logic t, input logic [5:0] p, input logic rst_n);
    int btn, nstate, ns, d, h, mi, s;
    bit lng, adv, hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    btn = 0; lng = 0;
    for (int b = 0; b < 3; b++)
      if (btn == 0 && (p[2*b] || p[2*b+1])) begin btn = b + 1; lng = p[2*b+1]; end
    nstate = m_state;
    adv = t && (m_state == 0 || m_state >= 3) && !(m_state == 0 && btn == 1 && lng);
    ns  = adv ? (m_secs + 1) % 86400 : m_secs;
    hit = ALARM && adv && m_armed != 0 && ns == m_al_h * 3600 + m_al_m * 60;
    if (btn == 1) begin
      if (m_state == 0) begin
        if (lng) begin nstate = 1; ns = ns - ns % 60; end
      end else if (lng) nstate = 0;
      else nstate = (m_state == 2 && !ALARM) ? 0 : (m_state + 1) % 5;
    end else if (btn >= 2 && m_state != 0) begin
      d = lng ? 10 : 1;
      if (btn == 3) d = -d;
      h = ns / 3600; mi = (ns / 60) % 60; s = ns % 60;
      case (m_state)
        1: h = (h + d + 24) % 24;
        2: mi = (mi + d + 60) % 60;
        3: m_al_h = (m_al_h + d + 24) % 24;
        default: m_al_m = (m_al_m + d + 60) % 60;
      endcase
      ns = h * 3600 + mi * 60 + s;
    end
    if (m_state != 0 && nstate == m_state) begin
      if (btn != 0) m_inact = 0;
      else if (t) begin
        m_inact++;
        if (m_inact == TIMEOUT) nstate = 0;
      end
    end
    if (nstate != m_state || nstate == 0) m_inact = 0;
    if (nstate == 0) m_blink = 0;
    else if (nstate != m_state) m_blink = 1;
    else if (t) m_blink = 1 - m_blink;
    if (ALARM) begin
      if (m_state == 0 && btn == 3 && lng && m_suna == 0) m_armed = 1 - m_armed;
      if (btn == 3) begin m_suna = 0; m_ring = 0; end
      else if (hit) begin m_suna = 1; m_ring = 0; end
      else if (m_suna != 0 && t) begin
        m_ring++;
        if (m_ring == DURATA) begin m_suna = 0; m_ring = 0; end
      end
    end
    m_secs = ns;
    m_state = nstate;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ore"},       32'(ore),           m_secs / 3600);
    chk({tag, ".minute"},    32'(minute),        (m_secs / 60) % 60);
    chk({tag, ".secunde"},   32'(secunde),       m_secs % 60);
    chk({tag, ".mod"},       32'(mod),           m_state);
    chk({tag, ".blink"},     32'(blink),         m_blink);
    chk({tag, ".al_ore"},    32'(al_ore),        m_al_h);
    chk({tag, ".al_minute"}, 32'(al_minute),     m_al_m);
    chk({tag, ".armed"},     32'(alarma_activa), m_armed);
    chk({tag, ".suna"},      32'(suna),          m_suna);
  endtask

  // Inputs change on the rising edge, the DUT acts on the falling edge, outputs are read 1 time unit later.
  task automatic cyc(input logic t, input logic [5:0] p, input logic rst_n);
    @(posedge clock);
    tick_1s = t;
    {lung_3, scurt_3, lung_2, scurt_2, lung_1, scurt_1} = p;
    reset = rst_n;
    @(negedge clock);
    model_step(t, p, rst_n);
    #1;
    tick_1s = 1'b0;
    {lung_3, scurt_3, lung_2, scurt_2, lung_1, scurt_1} = 6'b0;
    reset = 1'b1;
    check_all("cycle");
  endtask

  task automatic press(input logic [5:0] p);
    cyc(1'b0, p, 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 6'b0, 1'b1);
  endtask

  initial begin
    logic [5:0] p;
    logic       t, r;
    model_reset();

    cyc(1'b0, 6'b0, 1'b0);
    cyc(1'b0, 6'b0, 1'b0);
    chk("rst_mod", 32'(mod), 0);
    chk("rst_al_ore", 32'(al_ore), ALARM ? 7 : 0);
    chk("rst_suna", 32'(suna), 0);

    // Set the hour; seconds cleared on entry and frozen despite ticks.
    ticks(5);
    chk("run_sec", 32'(secunde), 5);
    press(P_L1);
    chk("enter_mod", 32'(mod), 1);
    chk("enter_sec", 32'(secunde), 0);
    chk("enter_blink", 32'(blink), 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, P_S2, 1'b1);
    chk("set_ore", 32'(ore), 3);
    chk("frozen_sec", 32'(secunde), 0);
    press(P_L1);
    chk("exit_mod", 32'(mod), 0);

    // Minute wrap in both directions.
    press(P_L1);
    press(P_S1);
    chk("set_min_mod", 32'(mod), 2);
    for (int i = 0; i < 5; i++) press(P_S3);
    chk("min_55", 32'(minute), 55);
    press(P_L2);
    chk("min_55p10", 32'(minute), 5);
    for (int i = 0; i < 6; i++) press(P_S3);
    chk("min_5m6", 32'(minute), 59);
    press(P_S1);
    chk("after_set_min", 32'(mod), ALARM ? 3 : 0);
    if (m_state != 0) press(P_L1);
    chk("back_normal", 32'(mod), 0);

    // Hour wrap, then day rollover from 23:59:58.
    press(P_L1);
    press(P_L2);
    press(P_L2);
    chk("ore_23", 32'(ore), 23);
    press(P_S2);
    chk("ore_23p1", 32'(ore), 0);
    press(P_S3);
    chk("ore_0m1", 32'(ore), 23);
    press(P_L1);
    ticks(58);
    chk("pre_roll_ore", 32'(ore), 23);
    chk("pre_roll_sec", 32'(secunde), 58);
    ticks(2);
    chk("roll_ore", 32'(ore), 0);
    chk("roll_min", 32'(minute), 0);
    chk("roll_sec", 32'(secunde), 0);

    // Inactivity timeout, then button priority.
    press(P_L1);
    ticks(TIMEOUT - 1);
    chk("timeout_early", 32'(mod), 1);
    ticks(1);
    chk("timeout_mod", 32'(mod), 0);
    press(P_L1 | P_S2);
    chk("prio_mod", 32'(mod), 1);
    chk("prio_ore", 32'(ore), 0);
    press(P_L2 | P_S3);
    chk("prio_b2", 32'(ore), 10);
    press(P_L1);

`ifdef CONTROL_SETARE_ALARMA_EN
    // Alarm 07:00 rung from 06:59:59, stopped by a button and then by the duration limit.
    for (int round = 0; round < 2; round++) begin
      press(P_L1);
      for (int k = 0; k < 30 && m_secs / 3600 != 6; k++) press(P_S3);
      press(P_S1);
      for (int k = 0; k < 70 && (m_secs / 60) % 60 != 59; k++) press(P_S3);
      press(P_L1);
      ticks(59);
      if (round == 0) begin
        press(P_L3);
        chk("armed", 32'(alarma_activa), 1);
      end
      ticks(1);
      chk("ring", 32'(suna), 1);
      chk("ring_ore", 32'(ore), 7);
      if (round == 0) begin
        press(P_S3);
        chk("stop_suna", 32'(suna), 0);
        chk("stop_armed", 32'(alarma_activa), 1);
      end else begin
        ticks(DURATA - 1);
        chk("ring_hold", 32'(suna), 1);
        ticks(1);
        chk("ring_done", 32'(suna), 0);
        chk("ring_armed", 32'(alarma_activa), 1);
      end
    end
`endif

    // Reset in the middle of an edit discards it.
    press(P_L1);
    press(P_S2);
    cyc(1'b0, 6'b0, 1'b0);
    chk("rst_edit_mod", 32'(mod), 0);
    chk("rst_edit_ore", 32'(ore), 0);
    chk("rst_edit_blink", 32'(blink), 0);

    // Random pulses, ticks and occasional resets against the model.
    for (int i = 0; i < 2000; i++) begin
      t = ($urandom_range(0, 1) == 0);
      for (int b = 0; b < 6; b++) p[b] = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 399) != 0);
      cyc(t, p, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
